// File: rtl/word_serializer.sv
// Serializes one latched BUS_DATA-wide word into BUS_BYTE chunks, LSB chunk first,
// over a valid/ready handshake; all outputs are registered.
module word_serializer #(
  parameter int BUS_DATA = 32,
  parameter int BUS_BYTE = 8
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [BUS_DATA-1:0] i_data,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [BUS_BYTE-1:0] o_byte,
  output logic                o_byte_valid,
  input  logic                i_byte_ready,
  output logic                o_busy,
  output logic                o_done
);

  localparam int N_CHUNKS = BUS_DATA / BUS_BYTE;
  localparam int CNT_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N_CHUNKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [BUS_DATA-1:0] r_shift;
  logic [BUS_DATA-1:0] w_shift_shifted;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ready;
  logic                r_byte_valid;
  logic                r_busy;
  logic                r_done;
  logic                w_accept;
  logic                w_take;

  // r_ready stays low for the first cycle after reset release, so no word is
  // taken while the upstream still sees o_ready=0.
  assign w_accept = (r_state == ST_IDLE) && r_ready && i_valid;
  assign w_take   = (r_state == ST_SEND) && i_byte_ready;

  generate
    for (genvar gi = 0; gi < N_CHUNKS; gi++) begin : g_shift
      if (gi < N_CHUNKS - 1) begin : g_mid
        assign w_shift_shifted[gi*BUS_BYTE +: BUS_BYTE] = r_shift[(gi+1)*BUS_BYTE +: BUS_BYTE];
      end else begin : g_top
        assign w_shift_shifted[gi*BUS_BYTE +: BUS_BYTE] = '0;
      end
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_SEND;
      ST_SEND: if (w_take && (r_cnt == LAST_CHUNK)) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The counter saturates at the last chunk rather than wrapping.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_shift <= i_data;
      r_cnt   <= '0;
    end else if (w_take) begin
      r_shift <= w_shift_shifted;
      r_cnt   <= (r_cnt == LAST_CHUNK) ? r_cnt : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_ready      <= 1'b0;
      r_byte_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_ready      <= (w_state_next == ST_IDLE);
      r_byte_valid <= (w_state_next == ST_SEND);
      r_busy       <= (w_state_next == ST_SEND) || (w_state_next == ST_DONE);
      r_done       <= (w_state_next == ST_DONE);
    end
  end

  assign o_ready      = r_ready;
  assign o_byte       = r_shift[BUS_BYTE-1:0];
  assign o_byte_valid = r_byte_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_word_serializer.sv
// Randomized and directed bench for word_serializer; a queue-based model of the
// pending chunks predicts every output each cycle.
module tb_word_serializer;

  logic        clk;
  logic        rst_n;

  logic [31:0] i_data;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic        i_byte_ready;
  logic        o_busy;
  logic        o_done;

  logic [7:0]  d8;
  logic        v8;
  logic        r8;
  logic [7:0]  b8;
  logic        bv8;
  logic        br8;
  logic        busy8;
  logic        done8;

  word_serializer #(.BUS_DATA(32), .BUS_BYTE(8)) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_byte       (o_byte),
    .o_byte_valid (o_byte_valid),
    .i_byte_ready (i_byte_ready),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  word_serializer #(.BUS_DATA(8), .BUS_BYTE(8)) dut8 (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_data       (d8),
    .i_valid      (v8),
    .o_ready      (r8),
    .o_byte       (b8),
    .o_byte_valid (bv8),
    .i_byte_ready (br8),
    .o_busy       (busy8),
    .o_done       (done8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: bytes still owed to the sink, plus done/ready flags.
  logic [7:0] m_q[$];
  bit         m_done;
  bit         m_ready;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic sample_outputs();
    check_eq("ready", {31'd0, o_ready}, {31'd0, m_ready});
    check_eq("byte_valid", {31'd0, o_byte_valid}, {31'd0, (m_q.size() > 0)});
    check_eq("busy", {31'd0, o_busy}, {31'd0, (m_q.size() > 0) || m_done});
    check_eq("done", {31'd0, o_done}, {31'd0, m_done});
    if (m_q.size() > 0) begin
      check_eq("byte", {24'd0, o_byte}, {24'd0, m_q[0]});
    end
  endtask

  // Called at a falling edge: check, drive, predict, advance one cycle.
  task automatic step(input logic v, input logic [31:0] d, input logic br);
    sample_outputs();
    i_valid      = v;
    i_data       = d;
    i_byte_ready = br;
    if (m_q.size() > 0) begin
      if (br) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_done = 1'b1;
      end
    end else if (m_done) begin
      m_done  = 1'b0;
      m_ready = 1'b1;
    end else if (m_ready && v) begin
      for (int k = 0; k < 4; k++) begin
        m_q.push_back(8'((d >> (8 * k)) & 32'hFF));
      end
      m_ready = 1'b0;
      $display("accept word %08h", d);
    end else begin
      m_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int hold_cycles);
    rst_n   = 1'b0;
    i_valid = 1'b0;
    #1;
    check_eq("rst_byte_valid", {31'd0, o_byte_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, o_busy}, 32'd0);
    check_eq("rst_done", {31'd0, o_done}, 32'd0);
    check_eq("rst_byte", {24'd0, o_byte}, 32'd0);
    check_eq("rst_ready", {31'd0, o_ready}, 32'd0);
    check_eq("rst8_byte", {24'd0, b8}, 32'd0);
    m_q.delete();
    m_done  = 1'b0;
    m_ready = 1'b0;
    repeat (hold_cycles) @(negedge clk);
    check_eq("rst_hold_ready", {31'd0, o_ready}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    i_data       = '0;
    i_valid      = 1'b0;
    i_byte_ready = 1'b0;
    d8           = '0;
    v8           = 1'b0;
    br8          = 1'b0;
    @(negedge clk);
    do_reset(2);

    // Ready after release, then DEADBEEF streamed with sink always ready.
    repeat (2) step(1'b0, 32'd0, 1'b1);
    step(1'b1, 32'hDEADBEEF, 1'b1);
    repeat (7) step(1'b0, 32'd0, 1'b1);

    // Sink stalls three cycles on the second chunk.
    step(1'b1, 32'hDEADBEEF, 1'b0);
    step(1'b0, 32'd0, 1'b1);
    repeat (3) step(1'b0, 32'd0, 1'b0);
    repeat (6) step(1'b0, 32'd0, 1'b1);

    // A new word offered during SEND and DONE must be ignored.
    step(1'b1, 32'hDEADBEEF, 1'b1);
    repeat (5) step(1'b1, 32'h11223344, 1'b1);
    repeat (2) step(1'b0, 32'd0, 1'b1);

    // Back-to-back offers.
    step(1'b1, 32'h01020304, 1'b1);
    repeat (6) step(1'b1, 32'h05060708, 1'b1);
    repeat (7) step(1'b0, 32'd0, 1'b1);

    // Reset in the middle of a word; nothing resumes afterwards.
    step(1'b1, 32'hCAFEF00D, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    do_reset(2);
    repeat (4) step(1'b0, 32'd0, 1'b1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 3) != 0));
    end
    repeat (8) step(1'b0, 32'd0, 1'b1);

    // Single-chunk instance.
    check_eq("n1_ready", {31'd0, r8}, 32'd1);
    v8  = 1'b1;
    d8  = 8'hA5;
    br8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v8 = 1'b0;
    check_eq("n1_valid", {31'd0, bv8}, 32'd1);
    check_eq("n1_byte", {24'd0, b8}, 32'h000000A5);
    check_eq("n1_busy", {31'd0, busy8}, 32'd1);
    check_eq("n1_ready_send", {31'd0, r8}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("n1_done", {31'd0, done8}, 32'd1);
    check_eq("n1_valid_done", {31'd0, bv8}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("n1_done_clear", {31'd0, done8}, 32'd0);
    check_eq("n1_ready_again", {31'd0, r8}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
